fifo_prog: RTL

Parametrised synchronous FIFO. It is the next generation of the team's fixed-threshold FIFO and adds the following:
- runtime-programmable almost_full/almost_empty thresholds
- an occupancy count output
- an optional first-word-fall-through (FWFT) read mode
- sticky, clearable overflow/underflow error flags
- non-power-of-two depth support

It sits between producer and consumer datapaths in a single clock domain.

---
 rtl/fifo_prog_if.sv | 35 +++
 rtl/fifo_prog.sv | 108 ++++++++++
 2 files changed

// File: rtl/fifo_prog_if.sv
// Handshake, threshold and status bundle between a fifo_prog instance and its user.
interface fifo_prog_if #(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 4
);
    logic                  write_en;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  read_en;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_valid;
    logic [CNT_WIDTH-1:0]  af_thresh;
    logic [CNT_WIDTH-1:0]  ae_thresh;
    logic [CNT_WIDTH-1:0]  count;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic                  overflow;
    logic                  underflow;
    logic                  err_clear;

    // User side: drives requests and thresholds, observes data and status.
    modport master (
        output write_en, data_in, read_en, af_thresh, ae_thresh, err_clear,
        input  data_out, data_valid, count, full, empty,
               almost_full, almost_empty, overflow, underflow
    );

    // FIFO side.
    modport slave (
        input  write_en, data_in, read_en, af_thresh, ae_thresh, err_clear,
        output data_out, data_valid, count, full, empty,
               almost_full, almost_empty, overflow, underflow
    );
endinterface

// File: rtl/fifo_prog.sv
// Synchronous FIFO with programmable almost_full/almost_empty thresholds,
// occupancy count, sticky error flags, optional FWFT read mode and
// arbitrary (non power-of-two) depth.
module fifo_prog #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int CNT_WIDTH  = $clog2(DEPTH + 1),
    parameter int FWFT       = 0
) (
    input logic        clk,
    input logic        reset,
    fifo_prog_if.slave bus
);
    localparam logic [CNT_WIDTH-1:0]  FULL_COUNT = CNT_WIDTH'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [CNT_WIDTH-1:0]  count_q;
    logic                  overflow_q;
    logic                  underflow_q;
    logic                  rd_ok;
    logic                  wr_ok;

    // Accept decisions; a full FIFO still takes a write when a read frees a slot.
    always_comb begin
        rd_ok = bus.read_en && (count_q != '0);
        wr_ok = bus.write_en && ((count_q != FULL_COUNT) || rd_ok);
    end

    // Storage write port; contents are never cleared by reset.
    always_ff @(posedge clk) begin
        if (!reset && wr_ok) begin
            mem[wr_ptr] <= bus.data_in;
        end
    end

    // Pointers, occupancy and sticky error flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= (wr_ptr == LAST_ADDR) ? '0 : wr_ptr + ADDR_WIDTH'(1);
            end
            if (rd_ok) begin
                rd_ptr <= (rd_ptr == LAST_ADDR) ? '0 : rd_ptr + ADDR_WIDTH'(1);
            end
            case ({wr_ok, rd_ok})
                2'b10:   count_q <= count_q + CNT_WIDTH'(1);
                2'b01:   count_q <= count_q - CNT_WIDTH'(1);
                default: count_q <= count_q;
            endcase
            // A fresh error outranks a clear in the same cycle.
            if (bus.write_en && !wr_ok) begin
                overflow_q <= 1'b1;
            end else if (bus.err_clear) begin
                overflow_q <= 1'b0;
            end
            if (bus.read_en && !rd_ok) begin
                underflow_q <= 1'b1;
            end else if (bus.err_clear) begin
                underflow_q <= 1'b0;
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is presented combinationally whenever the FIFO holds data.
            assign bus.data_out   = (count_q == '0) ? '0 : mem[rd_ptr];
            assign bus.data_valid = (count_q != '0);
        end else begin : g_std
            logic [DATA_WIDTH-1:0] dout_q;
            logic                  valid_q;

            // Registered read: head word loads on an accepted read, valid pulses once.
            always_ff @(posedge clk) begin
                if (reset) begin
                    dout_q  <= '0;
                    valid_q <= 1'b0;
                end else begin
                    valid_q <= rd_ok;
                    if (rd_ok) begin
                        dout_q <= mem[rd_ptr];
                    end
                end
            end

            assign bus.data_out   = dout_q;
            assign bus.data_valid = valid_q;
        end
    endgenerate

    assign bus.count        = count_q;
    assign bus.full         = (count_q == FULL_COUNT);
    assign bus.empty        = (count_q == '0);
    assign bus.almost_full  = (bus.af_thresh != '0) && (count_q >= bus.af_thresh);
    assign bus.almost_empty = (count_q <= bus.ae_thresh);
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
endmodule
